// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants, FSM state type and duty clamp helper for the PWM duty controller
package pwm_pkg;

  localparam int DUTY_W       = 4;
  localparam int MAX_DUTY     = 10;
  localparam int DEFAULT_DUTY = 5;

  typedef enum logic {IDLE, RAMP} state_t;

  function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] d);
    return (d > DUTY_W'(MAX_DUTY)) ? DUTY_W'(MAX_DUTY) : d;
  endfunction

endpackage

// File: rtl/pwm_ramp_div.sv
// rtl/pwm_ramp_div.sv - divides period_wrap pulses down to one ramp step every RAMP_DIV wraps
module pwm_ramp_div #(
  parameter int RAMP_DIV = 2,
  parameter int DIV_W    = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_period_wrap,
  output logic o_step
);

  localparam logic [DIV_W-1:0] LP_LAST = DIV_W'(RAMP_DIV - 1);

  logic [DIV_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LP_LAST);
  // Combinational so the owner registers the new duty on the very wrap that completes the count.
  assign o_step = i_period_wrap & ~i_clr & w_last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_period_wrap) begin
      r_cnt <= w_last ? '0 : r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/pwm_duty_ramp_ctrl.sv
// rtl/pwm_duty_ramp_ctrl.sv - duty register owner: host/button arbitration, clamp, boundary-aligned ramp
// Optional soft start on reset selected by PWM_SOFT_START_EN.
module pwm_duty_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int RAMP_DIV = 2,
  parameter int DIV_W    = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_period_wrap,
  input  logic              i_btn_inc,
  input  logic              i_btn_dec,
  input  logic              i_host_valid,
  input  logic [DUTY_W-1:0] i_host_duty,
  output logic              o_host_ready,
  output logic [DUTY_W-1:0] o_duty_out,
  output logic              o_duty_upd,
  output logic              o_busy,
  output logic              o_err_range
);

  localparam logic [DUTY_W-1:0] LP_MAX = DUTY_W'(MAX_DUTY);
  localparam logic [DUTY_W-1:0] LP_DEF = DUTY_W'(DEFAULT_DUTY);

  state_t            r_state;
  logic [DUTY_W-1:0] r_duty;
  logic [DUTY_W-1:0] r_target;
  logic              r_upd;
  logic              r_busy;
  logic              r_ready;
  logic              r_err;

  logic              w_step;
  logic              w_div_clr;
  logic [DUTY_W-1:0] w_host_tgt;
  logic [DUTY_W-1:0] w_next;

  assign w_div_clr  = (r_state != RAMP);
  assign w_host_tgt = clamp_duty(i_host_duty);
  assign w_next     = (r_target > r_duty) ? r_duty + DUTY_W'(1) : r_duty - DUTY_W'(1);

  pwm_ramp_div #(
    .RAMP_DIV(RAMP_DIV),
    .DIV_W   (DIV_W)
  ) u_div (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clr        (w_div_clr),
    .i_period_wrap(i_period_wrap),
    .o_step       (w_step)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_upd    <= 1'b0;
      r_err    <= 1'b0;
      r_target <= LP_DEF;
`ifdef PWM_SOFT_START_EN
      r_state  <= RAMP;
      r_duty   <= '0;
      r_busy   <= 1'b1;
      r_ready  <= 1'b0;
`else
      r_state  <= IDLE;
      r_duty   <= LP_DEF;
      r_busy   <= 1'b0;
      r_ready  <= 1'b1;
`endif
    end else begin
      r_upd <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          // Host transfer takes priority; a coincident button pulse is simply dropped.
          if (i_host_valid) begin
            r_target <= w_host_tgt;
            r_err    <= (i_host_duty > LP_MAX);
            if (w_host_tgt != r_duty) begin
              r_state <= RAMP;
              r_busy  <= 1'b1;
              r_ready <= 1'b0;
            end
          end else if (i_btn_inc && !i_btn_dec && (r_duty < LP_MAX)) begin
            r_target <= r_duty + DUTY_W'(1);
            r_state  <= RAMP;
            r_busy   <= 1'b1;
            r_ready  <= 1'b0;
          end else if (i_btn_dec && !i_btn_inc && (r_duty != '0)) begin
            r_target <= r_duty - DUTY_W'(1);
            r_state  <= RAMP;
            r_busy   <= 1'b1;
            r_ready  <= 1'b0;
          end
        end
        RAMP: begin
          if (w_step) begin
            r_duty <= w_next;
            r_upd  <= 1'b1;
            if (w_next == r_target) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_ready <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_duty_out   = r_duty;
  assign o_duty_upd   = r_upd;
  assign o_busy       = r_busy;
  assign o_host_ready = r_ready;
  assign o_err_range  = r_err;

endmodule
